// File: rtl/rca_8bit.sv
// 8-bit ripple-carry adder with a combinational sum/carry and a registered
// copy of sum, carry-out and signed overflow for synchronous consumers.
module rca_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic [WIDTH-1:0] S_q,
  output logic             Co_q,
  output logic             V_q
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic             v;

  // Full-adder chain: each cell's carry-out feeds the next cell's carry-in.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = Cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

  // Signed overflow: carries into and out of the sign bit disagree.
  assign v  = c[WIDTH] ^ c[WIDTH-1];
  assign S  = s;
  assign Co = c[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S_q  <= '0;
      Co_q <= 1'b0;
      V_q  <= 1'b0;
    end else begin
      S_q  <= s;
      Co_q <= c[WIDTH];
      V_q  <= v;
    end
  end

endmodule

// File: tb/tb_rca_8bit.sv
// Self-checking bench for rca_8bit: directed corner vectors, an asynchronous
// reset check and a random sweep against an arithmetic reference model.
module tb_rca_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b, s, s_q;
  logic       cin, co, co_q, v_q;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  rca_8bit dut (
    .clk  (clk),
    .rst  (rst),
    .A    (a),
    .B    (b),
    .Cin  (cin),
    .S    (s),
    .Co   (co),
    .S_q  (s_q),
    .Co_q (co_q),
    .V_q  (v_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one vector, check the combinational result, then the registered
  // copy one clock later against the plain-arithmetic model.
  task automatic vec(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                     input string tag);
    int eu, es;
    logic ev;
    a   = ai;
    b   = bi;
    cin = ci;
    eu  = 32'(ai) + 32'(bi) + 32'(ci);
    es  = 32'($signed(ai)) + 32'($signed(bi)) + 32'(ci);
    ev  = (es > 127) || (es < -128);
    #1;
    chk({tag, ".S"},  32'(s),  32'(eu[7:0]));
    chk({tag, ".Co"}, 32'(co), 32'(eu[8]));
    @(posedge clk);
    #1;
    chk({tag, ".S_q"},  32'(s_q),  32'(eu[7:0]));
    chk({tag, ".Co_q"}, 32'(co_q), 32'(eu[8]));
    chk({tag, ".V_q"},  32'(v_q),  32'(ev));
  endtask

  initial begin
    rst = 1'b1;
    a   = 8'h00;
    b   = 8'h00;
    cin = 1'b0;
    #1;
    chk("rst.S_q",  32'(s_q),  32'h0);
    chk("rst.Co_q", 32'(co_q), 32'h0);
    chk("rst.V_q",  32'(v_q),  32'h0);
    a = 8'h3C;
    b = 8'h0F;
    #1;
    chk("rst.comb_S", 32'(s), 32'h4B);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    vec(8'h00, 8'h00, 1'b0, "zero");
    vec(8'h01, 8'h01, 1'b0, "one_one");
    vec(8'h0F, 8'h0F, 1'b0, "ripple4");
    vec(8'hF0, 8'h0F, 1'b1, "full_ripple");
    vec(8'hAA, 8'h55, 1'b0, "aa55");
    vec(8'hFF, 8'hFF, 1'b1, "max");
    vec(8'h7F, 8'h01, 1'b0, "pos_ovf");
    vec(8'h80, 8'hFF, 1'b0, "neg_ovf");
    vec(8'h80, 8'h80, 1'b0, "neg_neg");

    // Async reset between edges while S_q holds FF.
    vec(8'hAA, 8'h55, 1'b0, "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.S_q",  32'(s_q),  32'h0);
    chk("async_rst.Co_q", 32'(co_q), 32'h0);
    chk("async_rst.V_q",  32'(v_q),  32'h0);
    chk("async_rst.S",    32'(s),    32'hFF);
    chk("async_rst.Co",   32'(co),   32'h0);
    @(posedge clk);
    #1;
    chk("rst_held.S_q", 32'(s_q), 32'h0);
    rst = 1'b0;
    vec(8'h01, 8'h01, 1'b0, "post_rst");

    for (int i = 0; i < 300; i++)
      vec(8'($urandom), 8'($urandom), 1'($urandom), "rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
